// File: rtl/gesture_packet_rx_pkg.sv
// Shared definitions for the gesture packet link: header constants, gesture
// encoding, state enums and the transmit-side packet builders.
package gesture_packet_rx_pkg;

   localparam logic [3:0] HDR_NIBBLE = 4'hA;
   localparam logic [5:0] HDR_MATCH  = {HDR_NIBBLE, 2'b00};

   typedef enum logic [1:0] {G_UP = 2'd0, G_DOWN = 2'd1, G_LEFT = 2'd2, G_RIGHT = 2'd3} gesture_e;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;
   typedef enum logic {P_HDR, P_BODY} parse_state_e;

   function automatic logic [7:0] build_hdr(input gesture_e g);
      return {HDR_NIBBLE, 2'b00, g};
   endfunction

   function automatic logic [7:0] build_body(input logic [3:0] conf, input logic [3:0] act);
      return {conf, act};
   endfunction

endpackage

// File: rtl/gesture_packet_rx_uart.sv
// 8N1 byte receiver: 2-flop synchronizer, mid-bit sampling, glitch rejection
// on the start bit and a one-cycle framing error on a bad stop bit.
module uart_rx
   import gesture_packet_rx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 104
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data,
   output logic       byte_valid,
   output logic       framing_err
);

   localparam int CW   = $clog2(CLKS_PER_BIT + 1);
   localparam int HALF = CLKS_PER_BIT / 2;

   rx_state_e         state_q, state_d;
   logic [1:0]        sync_q;
   logic              prev_q;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [2:0]        bit_q, bit_d;
   logic [7:0]        shift_q, shift_d;
   logic [7:0]        data_q, data_d;
   logic              bv_q, bv_d;
   logic              fe_q, fe_d;
   logic              rx_s;

   assign rx_s        = sync_q[1];
   assign data        = data_q;
   assign byte_valid  = bv_q;
   assign framing_err = fe_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q  <= 2'b11;
         prev_q  <= 1'b1;
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         bv_q    <= 1'b0;
         fe_q    <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], rx};
         prev_q  <= rx_s;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         bv_q    <= bv_d;
         fe_q    <= fe_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      bv_d    = 1'b0;
      fe_d    = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (prev_q && !rx_s) state_d = START;
         end
         START: begin
            // A start bit that is high again at mid-bit was only a glitch
            if (cnt_q == CW'(HALF - 1)) begin
               cnt_d = '0;
               bit_d = '0;
               state_d = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
               cnt_d   = '0;
               shift_d = {rx_s, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = STOP;
            end
         end
         STOP: begin
            if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
               cnt_d   = '0;
               state_d = IDLE;
               if (rx_s) begin
                  bv_d   = 1'b1;
                  data_d = shift_q;
               end else begin
                  fe_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: rtl/gesture_packet_rx.sv
// Two-byte gesture packet parser on top of the UART byte receiver, with an
// inter-byte timeout, latched decoded fields and a good-packet counter.
module gesture_packet_rx
   import gesture_packet_rx_pkg::*;
#(
   parameter int CLK_FREQ     = 12_000_000,
   parameter int BAUD_RATE    = 115200,
   parameter int TIMEOUT_BITS = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       uart_rx,
   output logic       packet_valid,
   output logic [1:0] gesture,
   output logic [3:0] confidence,
   output logic [3:0] activity,
   output logic [7:0] packet_count,
   output logic       header_err,
   output logic       framing_err,
   output logic       timeout_err
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int TIMEOUT_CLKS = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int TW           = $clog2(TIMEOUT_CLKS + 1);

   logic [7:0]   rx_data;
   logic         rx_valid, rx_ferr;

   parse_state_e pstate_q, pstate_d;
   logic [TW-1:0] tmo_q, tmo_d;
   gesture_e     g_q, g_d;
   logic [1:0]   gest_q, gest_d;
   logic [3:0]   conf_q, conf_d, act_q, act_d;
   logic [7:0]   cnt_q, cnt_d;
   logic         pv_q, pv_d, he_q, he_d;
   logic         timeout_hit;

   uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk        (clk),
      .rst        (rst),
      .rx         (uart_rx),
      .data       (rx_data),
      .byte_valid (rx_valid),
      .framing_err(rx_ferr)
   );

   assign packet_valid = pv_q;
   assign gesture      = gest_q;
   assign confidence   = conf_q;
   assign activity     = act_q;
   assign packet_count = cnt_q;
   assign header_err   = he_q;
   assign framing_err  = rx_ferr;
   // Combinational so the pulse lands exactly TIMEOUT_CLKS after the header byte
   assign timeout_err  = timeout_hit && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         pstate_q <= P_HDR;
         tmo_q    <= '0;
         g_q      <= G_UP;
         gest_q   <= '0;
         conf_q   <= '0;
         act_q    <= '0;
         cnt_q    <= '0;
         pv_q     <= 1'b0;
         he_q     <= 1'b0;
      end else begin
         pstate_q <= pstate_d;
         tmo_q    <= tmo_d;
         g_q      <= g_d;
         gest_q   <= gest_d;
         conf_q   <= conf_d;
         act_q    <= act_d;
         cnt_q    <= cnt_d;
         pv_q     <= pv_d;
         he_q     <= he_d;
      end
   end

   always_comb begin
      pstate_d    = pstate_q;
      tmo_d       = tmo_q;
      g_d         = g_q;
      gest_d      = gest_q;
      conf_d      = conf_q;
      act_d       = act_q;
      cnt_d       = cnt_q;
      pv_d        = 1'b0;
      he_d        = 1'b0;
      timeout_hit = 1'b0;
      case (pstate_q)
         P_HDR: begin
            if (rx_valid) begin
               if (rx_data[7:2] == HDR_MATCH) begin
                  g_d      = gesture_e'(rx_data[1:0]);
                  tmo_d    = '0;
                  pstate_d = P_BODY;
               end else begin
                  he_d = 1'b1;
               end
            end
         end
         P_BODY: begin
            // Body byte is taken positionally; a byte beats a same-cycle timeout
            if (rx_valid) begin
               pv_d     = 1'b1;
               gest_d   = g_q;
               conf_d   = rx_data[7:4];
               act_d    = rx_data[3:0];
               cnt_d    = cnt_q + 8'd1;
               pstate_d = P_HDR;
            end else if (rx_ferr) begin
               pstate_d = P_HDR;
            end else if (tmo_q == TW'(TIMEOUT_CLKS - 1)) begin
               timeout_hit = 1'b1;
               pstate_d    = P_HDR;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         default: pstate_d = P_HDR;
      endcase
   end

endmodule

// File: tb/tb_gesture_packet_rx.sv
// Directed bench for gesture_packet_rx, run at 10 clocks per bit so the
// 256-packet counter wrap stays short; timeout is 20 bits = 200 clocks.
module tb_gesture_packet_rx;
   import gesture_packet_rx_pkg::*;

   localparam int CPB     = 10;
   localparam int TO_CLKS = 200;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx  = 1'b1;
   logic       packet_valid, header_err, framing_err, timeout_err;
   logic [1:0] gesture;
   logic [3:0] confidence, activity;
   logic [7:0] packet_count;

   int n_cmp = 0, n_bad = 0;
   int pv_cnt, he_cnt, fe_cnt, to_cnt, bv_cnt, multi_cnt;
   int cyc = 0, bv_cyc = 0, to_cyc = 0;

   gesture_packet_rx #(.CLK_FREQ(12_000_000), .BAUD_RATE(1_200_000), .TIMEOUT_BITS(20)) dut (
      .clk(clk), .rst(rst), .uart_rx(rx),
      .packet_valid(packet_valid), .gesture(gesture), .confidence(confidence),
      .activity(activity), .packet_count(packet_count),
      .header_err(header_err), .framing_err(framing_err), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      cyc++;
      if (!rst) begin
         if (packet_valid) pv_cnt++;
         if (header_err)   he_cnt++;
         if (framing_err)  fe_cnt++;
         if (timeout_err) begin to_cnt++; to_cyc = cyc; end
         if (dut.u_rx.byte_valid) begin bv_cnt++; bv_cyc = cyc; end
         if (int'(header_err) + int'(framing_err) + int'(timeout_err) > 1) multi_cnt++;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
      $fatal(1);
   end

   task automatic clear_counts();
      pv_cnt = 0; he_cnt = 0; fe_cnt = 0; to_cnt = 0; bv_cnt = 0;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx = stop_bit;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; rx = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({packet_valid, gesture, confidence, activity, packet_count, header_err, framing_err, timeout_err} !== 23'd0) begin
         n_bad++; $display("FAIL reset_outputs: got %0h want 0",
            {packet_valid, gesture, confidence, activity, packet_count, header_err, framing_err, timeout_err});
      end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (packet_count !== 8'd0) begin n_bad++; $display("FAIL post_reset_count: got %0d want 0", packet_count); end
   endtask

   task automatic test_basic();
      clear_counts();
      send_byte(8'hA2, 1'b1);
      send_byte(8'h7C, 1'b1);
      n_cmp++; if (pv_cnt !== 1) begin n_bad++; $display("FAIL basic_pv: got %0d want 1", pv_cnt); end
      n_cmp++; if (gesture !== 2'd2) begin n_bad++; $display("FAIL basic_gesture: got %0d want 2", gesture); end
      n_cmp++; if (confidence !== 4'h7) begin n_bad++; $display("FAIL basic_conf: got %0h want 7", confidence); end
      n_cmp++; if (activity !== 4'hC) begin n_bad++; $display("FAIL basic_act: got %0h want c", activity); end
      n_cmp++; if (packet_count !== 8'd1) begin n_bad++; $display("FAIL basic_count: got %0d want 1", packet_count); end
      n_cmp++; if (he_cnt + fe_cnt + to_cnt !== 0) begin n_bad++; $display("FAIL basic_errs: got %0d want 0", he_cnt + fe_cnt + to_cnt); end
   endtask

   task automatic test_header();
      clear_counts();
      send_byte(8'h55, 1'b1);
      n_cmp++; if (he_cnt !== 1) begin n_bad++; $display("FAIL hdr_err: got %0d want 1", he_cnt); end
      n_cmp++; if (pv_cnt !== 0) begin n_bad++; $display("FAIL hdr_no_pv: got %0d want 0", pv_cnt); end
      send_byte(8'hA1, 1'b1);
      send_byte(8'h30, 1'b1);
      n_cmp++; if (pv_cnt !== 1) begin n_bad++; $display("FAIL hdr_pv: got %0d want 1", pv_cnt); end
      n_cmp++; if ({gesture, confidence, activity} !== {2'd1, 4'h3, 4'h0}) begin
         n_bad++; $display("FAIL hdr_fields: got g%0d c%0h a%0h want g1 c3 a0", gesture, confidence, activity); end
      n_cmp++; if (packet_count !== 8'd2) begin n_bad++; $display("FAIL hdr_count: got %0d want 2", packet_count); end
   endtask

   task automatic test_timeout();
      clear_counts();
      send_byte(8'hA3, 1'b1);
      repeat (3000) @(negedge clk);
      n_cmp++; if (to_cnt !== 1) begin n_bad++; $display("FAIL to_count: got %0d want 1", to_cnt); end
      n_cmp++; if (to_cyc - bv_cyc !== TO_CLKS) begin n_bad++; $display("FAIL to_latency: got %0d want %0d", to_cyc - bv_cyc, TO_CLKS); end
      n_cmp++; if (pv_cnt !== 0 || gesture !== 2'd1 || packet_count !== 8'd2) begin
         n_bad++; $display("FAIL to_no_packet: got pv%0d g%0d n%0d want pv0 g1 n2", pv_cnt, gesture, packet_count); end
      send_byte(8'hA0, 1'b1);
      send_byte(8'hF0, 1'b1);
      n_cmp++; if ({gesture, confidence, activity} !== {2'd0, 4'hF, 4'h0}) begin
         n_bad++; $display("FAIL to_recover: got g%0d c%0h a%0h want g0 cf a0", gesture, confidence, activity); end
      n_cmp++; if (packet_count !== 8'd3) begin n_bad++; $display("FAIL to_count_after: got %0d want 3", packet_count); end
   endtask

   task automatic test_framing();
      clear_counts();
      send_byte(8'hA2, 1'b0);
      n_cmp++; if (fe_cnt !== 1 || he_cnt !== 0) begin n_bad++; $display("FAIL fe_hdr: got fe%0d he%0d want fe1 he0", fe_cnt, he_cnt); end
      send_byte(8'hA1, 1'b1);
      send_byte(8'h11, 1'b1);
      n_cmp++; if ({pv_cnt[3:0], gesture, confidence, activity} !== {4'd1, 2'd1, 4'h1, 4'h1}) begin
         n_bad++; $display("FAIL fe_recover: got pv%0d g%0d c%0h a%0h want pv1 g1 c1 a1", pv_cnt, gesture, confidence, activity); end
      send_byte(8'hA2, 1'b1);
      send_byte(8'h7C, 1'b0);
      n_cmp++; if (fe_cnt !== 2 || pv_cnt !== 1 || to_cnt !== 0 || he_cnt !== 0) begin
         n_bad++; $display("FAIL fe_body_abort: got fe%0d pv%0d to%0d he%0d want fe2 pv1 to0 he0", fe_cnt, pv_cnt, to_cnt, he_cnt); end
      send_byte(8'hA3, 1'b1);
      send_byte(8'h45, 1'b1);
      n_cmp++; if ({gesture, confidence, activity, packet_count} !== {2'd3, 4'h4, 4'h5, 8'd5}) begin
         n_bad++; $display("FAIL fe_after_abort: got g%0d c%0h a%0h n%0d want g3 c4 a5 n5", gesture, confidence, activity, packet_count); end
   endtask

   task automatic test_glitch_wrap();
      logic [7:0] iv;
      clear_counts();
      rx = 1'b0;
      repeat (3) @(negedge clk);
      rx = 1'b1;
      repeat (40) @(negedge clk);
      n_cmp++; if (bv_cnt + fe_cnt + he_cnt + to_cnt !== 0) begin
         n_bad++; $display("FAIL glitch: got bv%0d fe%0d he%0d to%0d want all 0", bv_cnt, fe_cnt, he_cnt, to_cnt); end
      for (int i = 0; i < 251; i++) begin
         iv = 8'(i);
         send_byte(build_hdr(gesture_e'(iv[1:0])), 1'b1);
         send_byte(build_body(iv[3:0], ~iv[3:0]), 1'b1);
         if (i == 249) begin
            n_cmp++; if (packet_count !== 8'd255) begin n_bad++; $display("FAIL wrap_255: got %0d want 255", packet_count); end
         end
      end
      n_cmp++; if (packet_count !== 8'd0) begin n_bad++; $display("FAIL wrap_0: got %0d want 0", packet_count); end
      n_cmp++; if (pv_cnt !== 251) begin n_bad++; $display("FAIL wrap_pv: got %0d want 251", pv_cnt); end
      n_cmp++; if ({gesture, confidence, activity} !== {2'd2, 4'hA, 4'h5}) begin
         n_bad++; $display("FAIL wrap_last: got g%0d c%0h a%0h want g2 ca a5", gesture, confidence, activity); end
   endtask

   task automatic test_reset_mid();
      clear_counts();
      send_byte(8'hA2, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_cmp++; if ({gesture, confidence, activity, packet_count} !== 18'd0) begin
         n_bad++; $display("FAIL mid_rst_clear: got g%0d c%0h a%0h n%0d want 0", gesture, confidence, activity, packet_count); end
      send_byte(8'h7C, 1'b1);
      n_cmp++; if (he_cnt !== 1) begin n_bad++; $display("FAIL mid_rst_hdr: got %0d want 1", he_cnt); end
      n_cmp++; if (pv_cnt !== 0) begin n_bad++; $display("FAIL mid_rst_pv: got %0d want 0", pv_cnt); end
   endtask

   initial begin
      multi_cnt = 0;
      clear_counts();
      @(negedge clk);
      test_reset();
      test_basic();
      test_header();
      test_timeout();
      test_framing();
      test_glitch_wrap();
      test_reset_mid();
      n_cmp++; if (multi_cnt !== 0) begin n_bad++; $display("FAIL err_exclusive: got %0d cycles want 0", multi_cnt); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
